// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with runtime prescaler,
// optional parity, one or two stop bits and back-to-back frame acceptance.
// All frame settings are captured when a frame is accepted, so the inputs
// may change while a frame is on the line.
module uart_tx_frame #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   STOP2,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
  output logic                   TX_OUT,
  output logic                   busy,
  output logic                   tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1'b1);
  localparam logic [IDX_W-1:0]       IDX_ONE   = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity over the data word; odd parity is the inverse of even parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                  state_q;
  logic [PRESC_WIDTH-1:0]  presc_cnt_q;
  logic [PRESC_WIDTH-1:0]  pe_q;
  logic [IDX_W-1:0]        bit_idx_q;
  logic                    stop_cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    stop2_q;
  logic                    tx_q;
  logic                    busy_q;

  logic [PRESC_WIDTH-1:0]  pe_in_d;
  logic                    bit_end_d;
  logic                    last_stop_d;
  logic                    tx_done_d;
  logic                    accept_d;

  // Decode bit boundaries, end of frame and acceptance from registered state.
  always_comb begin
    pe_in_d     = PRESCALE;
    bit_end_d   = 1'b0;
    last_stop_d = 1'b0;
    tx_done_d   = 1'b0;
    accept_d    = 1'b0;
    if (PRESCALE == '0) begin
      pe_in_d = PRESC_ONE;
    end else begin
      pe_in_d = PRESCALE;
    end
    bit_end_d   = (presc_cnt_q == (pe_q - PRESC_ONE));
    last_stop_d = (stop_cnt_q == stop2_q);
    if (state_q == S_STOP) begin
      tx_done_d = bit_end_d && last_stop_d;
    end else begin
      tx_done_d = 1'b0;
    end
    accept_d = Data_Valid && ((state_q == S_IDLE) || tx_done_d);
  end

  // Frame sequencer: captures settings on acceptance and walks the frame bits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      presc_cnt_q <= '0;
      pe_q        <= PRESC_ONE;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else if (accept_d) begin
      state_q     <= S_START;
      presc_cnt_q <= '0;
      pe_q        <= pe_in_d;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      data_q      <= P_DATA;
      par_en_q    <= PAR_EN;
      par_bit_q   <= calc_parity(P_DATA, PAR_TYP);
      stop2_q     <= STOP2;
      tx_q        <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_cnt_q <= '0;
          tx_q        <= 1'b1;
          busy_q      <= 1'b0;
        end
        S_START: begin
          if (bit_end_d) begin
            presc_cnt_q <= '0;
            state_q     <= S_DATA;
            tx_q        <= data_q[0];
          end else begin
            presc_cnt_q <= presc_cnt_q + PRESC_ONE;
          end
        end
        S_DATA: begin
          if (bit_end_d) begin
            presc_cnt_q <= '0;
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_q <= '0;
              if (par_en_q) begin
                state_q <= S_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= S_STOP;
                stop_cnt_q <= 1'b0;
                tx_q       <= 1'b1;
              end
            end else begin
              // data_q shifts so the next data bit is always at index 1
              bit_idx_q <= bit_idx_q + IDX_ONE;
              tx_q      <= data_q[1];
              data_q    <= {1'b0, data_q[DATA_WIDTH-1:1]};
            end
          end else begin
            presc_cnt_q <= presc_cnt_q + PRESC_ONE;
          end
        end
        S_PARITY: begin
          if (bit_end_d) begin
            presc_cnt_q <= '0;
            state_q     <= S_STOP;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
          end else begin
            presc_cnt_q <= presc_cnt_q + PRESC_ONE;
          end
        end
        S_STOP: begin
          if (bit_end_d) begin
            presc_cnt_q <= '0;
            if (last_stop_d) begin
              state_q    <= S_IDLE;
              stop_cnt_q <= 1'b0;
              tx_q       <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end else begin
            presc_cnt_q <= presc_cnt_q + PRESC_ONE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          presc_cnt_q <= '0;
          bit_idx_q   <= '0;
          stop_cnt_q  <= 1'b0;
          tx_q        <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT  = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_d;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame: an 8-bit instance and a 5-bit
// instance sharing clock, reset and per-frame configuration inputs.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] pd8;
  logic [4:0] pd5;
  logic       dv8;
  logic       dv5;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [5:0] PRESCALE;
  logic       tx8, busy8, done8;
  logic       tx5, busy5, done5;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_tx, cap_busy, cap_done;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(pd8), .Data_Valid(dv8),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
    .TX_OUT(tx8), .busy(busy8), .tx_done(done8)
  );

  uart_tx_frame #(.DATA_WIDTH(5), .PRESC_WIDTH(6)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(pd5), .Data_Valid(dv5),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
    .TX_OUT(tx5), .busy(busy5), .tx_done(done5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lowmask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // Stretch a bit list (bit 0 first on the line) to Pe cycles per bit.
  function automatic logic [63:0] expand(input logic [63:0] bits, input int nb, input int pe);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < nb * pe; i++) r[i] = bits[i / pe];
    return r;
  endfunction

  // Idle line (1) for cycles len..n-1 after the frame.
  function automatic logic [63:0] pad(input logic [63:0] v, input int len, input int n);
    return v | (lowmask(n) & ~lowmask(len));
  endfunction

  // Sample n cycles at negedges; drop Data_Valid at drop_at; disturb inputs at act_at.
  task automatic capture(input int sel, input int n, input int drop_at, input int act_at);
    cap_tx = 64'd0; cap_busy = 64'd0; cap_done = 64'd0;
    for (int i = 0; i < n; i++) begin
      if (sel == 8) begin
        cap_tx[i] = tx8; cap_busy[i] = busy8; cap_done[i] = done8;
      end else begin
        cap_tx[i] = tx5; cap_busy[i] = busy5; cap_done[i] = done5;
      end
      if (i == drop_at) begin
        dv8 = 1'b0; dv5 = 1'b0;
      end
      if (i == act_at) begin
        dv8 = 1'b1; pd8 = 8'h3C; PRESCALE = 6'd7; PAR_EN = ~PAR_EN;
      end
      @(negedge CLK);
    end
  endtask

  task automatic start8(input logic [7:0] d);
    pd8 = d; dv8 = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0; pd8 = 8'h00; pd5 = 5'h00; dv8 = 1'b0; dv5 = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd1;
    repeat (3) @(negedge CLK);
    check("reset_tx8",   64'(tx8),   64'd1);
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_tx5",   64'(tx5),   64'd1);
    RST = 1'b1;
    @(negedge CLK);

    // Basic frame 0x53, Pe=1, no parity, one stop
    start8(8'h53);
    capture(8, 12, 0, -1);
    check("basic_tx",   cap_tx,   64'b111010100110);
    check("basic_busy", cap_busy, 64'b001111111111);
    check("basic_done", cap_done, 64'b001000000000);

    // Even parity, Pe=3: parity bit 1
    PRESCALE = 6'd3; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    start8(8'h07);
    capture(8, 35, 0, -1);
    check("par_even_tx",   cap_tx,   pad(expand({1'b1, 1'b1, 8'h07, 1'b0}, 11, 3), 33, 35));
    check("par_even_bit",  64'(cap_tx[28]), 64'd1);
    check("par_even_busy", cap_busy, lowmask(33));
    check("par_even_done", cap_done, 64'd1 << 32);

    // Odd parity: parity bit 0
    PAR_TYP = 1'b1;
    start8(8'h07);
    capture(8, 35, 0, -1);
    check("par_odd_tx",  cap_tx, pad(expand({1'b1, 1'b0, 8'h07, 1'b0}, 11, 3), 33, 35));
    check("par_odd_bit", 64'(cap_tx[28]), 64'd0);

    // Two stop bits: 6 high stop cycles, 36-cycle frame
    PAR_TYP = 1'b0; STOP2 = 1'b1;
    start8(8'h07);
    capture(8, 38, 0, -1);
    check("stop2_tx",   cap_tx,   pad(expand({2'b11, 1'b1, 8'h07, 1'b0}, 12, 3), 36, 38));
    check("stop2_busy", cap_busy, lowmask(36));
    check("stop2_done", cap_done, 64'd1 << 35);

    // Back-to-back 0x01 then 0xFF, Pe=2, Data_Valid held
    STOP2 = 1'b0; PAR_EN = 1'b0; PRESCALE = 6'd2;
    start8(8'h01);
    pd8 = 8'hFF;
    capture(8, 42, 39, -1);
    check("b2b_tx",   cap_tx,   pad(expand({1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 1'b0}, 20, 2), 40, 42));
    check("b2b_busy", cap_busy, lowmask(40));
    check("b2b_done", cap_done, (64'd1 << 19) | (64'd1 << 39));

    // Ignore request and config changes mid-frame
    PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 6'd2;
    start8(8'hA5);
    dv8 = 1'b0;
    capture(8, 28, 7, 6);
    check("ignore_tx",   cap_tx,   pad(expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 2), 22, 28));
    check("ignore_busy", cap_busy, lowmask(22));
    check("ignore_done", cap_done, 64'd1 << 21);

    // Reset during the fifth bit, then a clean frame right after release
    PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 6'd4;
    start8(8'hA5);
    capture(8, 17, 0, -1);
    check("rst_partial_tx", cap_tx, expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4) & lowmask(17));
    RST = 1'b0;
    #1;
    check("rst_mid_tx",   64'(tx8),   64'd1);
    check("rst_mid_busy", 64'(busy8), 64'd0);
    check("rst_mid_done", 64'(done8), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    start8(8'hA5);
    capture(8, 46, 0, -1);
    check("rst_after_tx",   cap_tx,   pad(expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4), 44, 46));
    check("rst_after_busy", cap_busy, lowmask(44));

    // 5-bit instance, PRESCALE=0 acts as 1, odd parity of 5'h1F is 0
    PRESCALE = 6'd0; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    pd5 = 5'h1F; dv5 = 1'b1;
    @(negedge CLK);
    capture(5, 10, 0, -1);
    check("w5_tx",   cap_tx,   64'b1110111110);
    check("w5_busy", cap_busy, lowmask(8));
    check("w5_done", cap_done, 64'd1 << 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter and next-generation serial TX engine of the low-power multi-clock system; it sits in the UART clock domain between the async-FIFO read side and the TX pad.
- Adds configurable data width, a runtime baud prescaler, selectable 1/2 stop bits and back-to-back frame acceptance with no idle gap.
- Per-frame configuration is captured at acceptance, so settings may change while a frame is in flight without corrupting it.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9 supported)
- PRESC_WIDTH, 6, width of PRESCALE input
- CLK  input  1  transmitter clock, all logic on rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  DATA_WIDTH  parallel data, sampled on acceptance
- Data_Valid  input  1  request to send P_DATA
- PAR_EN  input  1  1 = parity bit inserted
- PAR_TYP  input  1  0 = even, 1 = odd parity
- STOP2  input  1  1 = two stop bits, 0 = one
- PRESCALE  input  PRESC_WIDTH  CLK cycles per bit; 0 treated as 1
- TX_OUT  output  1  serial line, registered
- busy  output  1  frame in progress, registered
- tx_done  output  1  one-cycle pulse, final cycle of last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0.
- Acceptance occurs on a rising edge with Data_Valid=1 and either:
  - state IDLE, or
  - state STOP in the final cycle of the last stop bit (tx_done=1).
- At acceptance, the block latches:
  - P_DATA, PAR_EN, PAR_TYP, STOP2 and the effective PRESCALE (Pe);
  - parity = ^P_DATA for even, ~^P_DATA for odd.
- Data_Valid at any other time is ignored; no queuing.
- The frame is sent in this order, each bit lasting Pe cycles:
  - START: one 0 bit.
  - DATA: DATA_WIDTH bits, LSB first.
  - PARITY: present only if latched PAR_EN=1.
  - STOP: one 1 bit, or two if latched STOP2=1.
- Counters:
  - The prescale counter counts 0..Pe-1; reaching Pe-1 advances the bit.
  - The bit index counter is log2-sized for DATA_WIDTH, wraps to 0 on DATA exit.
  - The stop counter tracks 1 or 2 stop bits.
- Exiting STOP:
  - with acceptance: go to START (busy stays 1);
  - without acceptance: go to IDLE.
- Input changes after acceptance have no effect on the current frame.
- Reset (RST=0), any time including mid-frame:
  - TX_OUT=1, busy=0, tx_done=0 immediately;
  - state IDLE, all counters 0.
  - A partial frame is abandoned; the line reads as idle/break-free.
  - The first acceptance is possible on the first rising edge after RST deasserts.

## Timing
- Accept at edge k: from edge k, TX_OUT=0 and busy=1 (start bit visible in the cycle after edge k).
- Bit n (start = 0) spans edges k+n·Pe .. k+(n+1)·Pe-1.
- Frame length is L·Pe cycles, with L = 1 + DATA_WIDTH + PAR_EN + (1 + STOP2).
  - Example: DATA_WIDTH=8, parity on, two stops gives L = 12.
- tx_done=1 combinationally decoded from registered state during cycle k+L·Pe-1 only.
- Without a new request, busy falls at edge k+L·Pe.
- Back-to-back:
  - Data_Valid=1 while tx_done=1 produces START at edge k+L·Pe.
  - There is zero idle cycles between frames; busy never drops.
- Pe=1: one bit per cycle, all rules unchanged.
- PRESCALE changes mid-frame are ignored until the next acceptance.

## Test plan
- Reset mid-frame:
  - Stimulus: DATA_WIDTH=8, PRESCALE=4, P_DATA=0xA5, even parity, STOP2=0, RST low at the 5th bit.
  - Response: TX_OUT=1, busy=0 instantly; next accept produces a clean frame.
- Basic frame:
  - Stimulus: PRESCALE=1, P_DATA=0x53, PAR_EN=0, STOP2=0.
  - Response: TX_OUT sequence 0,1,1,0,0,1,0,1,0,1, one bit per cycle; busy high 10 cycles; tx_done at cycle 10.
- Parity and stop bits:
  - Stimulus: PRESCALE=3, P_DATA=0x07, PAR_EN=1, PAR_TYP=0.
  - Response: parity bit 1; then repeat with PAR_TYP=1, giving parity bit 0.
  - Additional check: STOP2=1 gives a 6-cycle high stop; total frame 36 cycles.
- Back-to-back:
  - Stimulus: Data_Valid held high, P_DATA 0x01 then 0xFF, PRESCALE=2.
  - Response: second START begins the cycle after first frame's last stop cycle; busy continuously 1 for 40 cycles.
- Ignore-while-busy and config latch:
  - Stimulus: pulse Data_Valid with P_DATA=0x3C mid-frame, and toggle PRESCALE and PAR_EN mid-frame.
  - Response: current frame bits and timing unchanged; no second frame sent.
- Width and prescale corners:
  - Stimulus: DATA_WIDTH=5, PRESCALE=0, P_DATA=5'h1F, odd parity.
  - Response: Pe=1; frame 0,1,1,1,1,1,0(parity),1 in 8 cycles.
